// File: rtl/mac_seq.sv
// Dot-product sequencer: CLEAR, then MUL/MAC per operand pair, then SAT, two drain CLEARs and result capture.
// start->done is len+6 cycles plus one per operand bubble; op_ready only in OPS, and bubbles stall the datapath.
module mac_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [2:0]       mac_instr,
  output logic [15:0]      mac_mplier,
  output logic [15:0]      mac_mcand,
  output logic             mac_stall,
  input  logic [7:0]       mac_protect,
  input  logic [31:0]      mac_result,
  output logic             busy,
  output logic             done,
  output logic [31:0]      dot_result,
  output logic [7:0]       dot_protect
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_OPS,
    S_SAT,
    S_DR1,
    S_DR2,
    S_CAP
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_MAC   = 2'b10;
  localparam logic [1:0] OP_SAT   = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic             mode_q;
  logic [LEN_W-1:0] cnt;
  logic             first_q;
  logic             xfer;

  assign xfer = (state == S_OPS) && op_valid;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      cnt         <= '0;
      first_q     <= 1'b0;
      done        <= 1'b0;
      dot_result  <= '0;
      dot_protect <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_CAP);
      if (state == S_IDLE && start) begin
        mode_q <= mode;
        cnt    <= len;
      end
      // The first accepted pair must overwrite the cleared accumulator (MUL), later ones accumulate.
      if (state == S_CLR) begin
        first_q <= 1'b1;
      end
      if (xfer) begin
        cnt     <= cnt - LEN_W'(1);
        first_q <= 1'b0;
      end
      if (state == S_CAP) begin
        dot_result  <= mac_result;
        dot_protect <= mac_protect;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mac_instr  = {mode_q, OP_CLEAR};
    mac_stall  = 1'b1;
    op_ready   = 1'b0;
    mac_mplier = '0;
    mac_mcand  = '0;
    case (state)
      S_IDLE: begin
        mac_instr = 3'b000;
        if (start) begin
          state_nxt = S_CLR;
        end
      end
      S_CLR: begin
        mac_stall = 1'b0;
        state_nxt = (cnt == '0) ? S_SAT : S_OPS;
      end
      S_OPS: begin
        op_ready   = 1'b1;
        mac_mplier = op_a;
        mac_mcand  = op_b;
        mac_instr  = {mode_q, first_q ? OP_MUL : OP_MAC};
        mac_stall  = ~op_valid;
        if (op_valid && cnt == LEN_W'(1)) begin
          state_nxt = S_SAT;
        end
      end
      S_SAT: begin
        mac_instr = {mode_q, OP_SAT};
        mac_stall = 1'b0;
        state_nxt = S_DR1;
      end
      // Two drain CLEARs push the SAT value out of the datapath queue and leave it cleared.
      S_DR1: begin
        mac_stall = 1'b0;
        state_nxt = S_DR2;
      end
      S_DR2: begin
        mac_stall = 1'b0;
        state_nxt = S_CAP;
      end
      S_CAP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural mac datapath and a per-cycle expected trace built from job descriptions.
module tb_mac_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [7:0]  len;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  mac_instr;
  logic [15:0] mac_mplier;
  logic [15:0] mac_mcand;
  logic        mac_stall;
  logic [7:0]  mac_protect;
  logic [31:0] mac_result;
  logic        busy;
  logic        done;
  logic [31:0] dot_result;
  logic [7:0]  dot_protect;

  always #5 clk = ~clk;

  mac_seq #(.LEN_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .mode        (mode),
    .len         (len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .mac_instr   (mac_instr),
    .mac_mplier  (mac_mplier),
    .mac_mcand   (mac_mcand),
    .mac_stall   (mac_stall),
    .mac_protect (mac_protect),
    .mac_result  (mac_result),
    .busy        (busy),
    .done        (done),
    .dot_result  (dot_result),
    .dot_protect (dot_protect)
  );

  // Datapath model: 40-bit accumulator (or two 20-bit lanes), result 2 unstalled edges after sampling.
  function automatic logic [19:0] sat20(input logic [19:0] v);
    logic signed [19:0] s;
    s = v;
    if (s > 20'sh07FFF) return 20'h07FFF;
    if (s < 20'shF8000) return 20'hF8000;
    return v;
  endfunction

  function automatic logic [39:0] sat40(input logic [39:0] v);
    logic signed [39:0] s;
    s = v;
    if (s > 40'sh007FFFFFFF) return 40'h007FFFFFFF;
    if (s < 40'shFF80000000) return 40'hFF80000000;
    return v;
  endfunction

  function automatic logic [39:0] dp_next(input logic [2:0] ins, input logic [39:0] a,
                                          input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] p;
    logic signed [15:0] ph;
    logic signed [15:0] pl;
    logic [39:0]        r;
    p  = $signed(x) * $signed(y);
    ph = $signed(x[15:8]) * $signed(y[15:8]);
    pl = $signed(x[7:0]) * $signed(y[7:0]);
    r  = a;
    if (!ins[2]) begin
      case (ins[1:0])
        2'b00:   r = '0;
        2'b01:   r = {{8{p[31]}}, p};
        2'b10:   r = a + {{8{p[31]}}, p};
        default: r = sat40(a);
      endcase
    end else begin
      case (ins[1:0])
        2'b00:   r = '0;
        2'b01:   r = {{4{ph[15]}}, ph, {4{pl[15]}}, pl};
        2'b10:   r = {a[39:20] + {{4{ph[15]}}, ph}, a[19:0] + {{4{pl[15]}}, pl}};
        default: r = {sat20(a[39:20]), sat20(a[19:0])};
      endcase
    end
    return r;
  endfunction

  function automatic logic [39:0] dp_fmt(input logic m, input logic [39:0] a);
    return m ? {a[39:36], a[19:16], a[35:20], a[15:0]} : a;
  endfunction

  logic [39:0] dp_acc = '0;
  logic [39:0] dp_q0  = '0;
  logic [39:0] dp_q1  = '0;
  logic [39:0] dp_q2  = '0;

  always @(posedge clk) begin
    if (!mac_stall) begin
      dp_acc <= dp_next(mac_instr, dp_acc, mac_mplier, mac_mcand);
      dp_q0  <= dp_fmt(mac_instr[2], dp_next(mac_instr, dp_acc, mac_mplier, mac_mcand));
      dp_q1  <= dp_q0;
      dp_q2  <= dp_q1;
    end
  end

  assign mac_result  = dp_q2[31:0];
  assign mac_protect = dp_q2[39:32];

  // Checking infrastructure
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic        chk_en = 1'b0;
  logic        exp_busy, exp_done, exp_ready, exp_stall, exp_ichk;
  logic [2:0]  exp_instr;
  logic [15:0] exp_mpl, exp_mcd;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("op_ready", 32'(op_ready), 32'(exp_ready));
      chk("mac_stall", 32'(mac_stall), 32'(exp_stall));
      if (exp_ichk) chk("mac_instr", 32'(mac_instr), 32'(exp_instr));
      chk("mac_mplier", 32'(mac_mplier), 32'(exp_mpl));
      chk("mac_mcand", 32'(mac_mcand), 32'(exp_mcd));
    end
  end

  int cyc_cnt  = 0;
  int done_cyc = -1;
  int s_mark   = 0;
  always @(posedge clk) cyc_cnt++;
  always @(posedge done) done_cyc = cyc_cnt;

  // Job description
  logic [15:0] pa [8];
  logic [15:0] pb [8];
  int          bub [8];
  logic        cur_m;
  int          cur_n;
  logic        pending_done = 1'b0;

  // Drives one cycle's inputs and expectations at posedge+1, then advances to the next posedge+1.
  task automatic cyc(input logic st, input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic e_busy, input logic e_ready, input logic e_stall,
                     input logic [2:0] e_instr, input logic e_ichk, input logic e_pass);
    start     = st;
    mode      = st && !busy ? cur_m : ~cur_m;
    len       = st && !busy ? 8'(cur_n) : 8'(cur_n + 7);
    op_valid  = v;
    op_a      = a;
    op_b      = b;
    exp_busy  = e_busy;
    exp_done  = pending_done;
    exp_ready = e_ready;
    exp_stall = e_stall;
    exp_instr = e_instr;
    exp_ichk  = e_ichk;
    exp_mpl   = e_pass ? a : 16'h0;
    exp_mcd   = e_pass ? b : 16'h0;
    pending_done = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic set_pairs(input int n, input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 8; i++) begin
      pa[i]  = a + 16'(i);
      pb[i]  = b;
      bub[i] = 0;
    end
    cur_n = n;
  endtask

  task automatic run_job(input logic m, input bit pre_v, input bit busy_st,
                         input logic [31:0] er, input logic [7:0] ep, input int elat);
    logic [1:0] opc;
    cur_m    = m;
    done_cyc = -1;
    s_mark   = cyc_cnt;
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    cyc(1'b0, pre_v, pa[0], pb[0], 1'b1, 1'b0, 1'b0, {m, 2'b00}, 1'b1, 1'b0);
    for (int i = 0; i < cur_n; i++) begin
      opc = (i == 0) ? 2'b01 : 2'b10;
      for (int j = 0; j < bub[i]; j++)
        cyc(busy_st, 1'b0, pa[i], pb[i], 1'b1, 1'b1, 1'b1, {m, opc}, 1'b1, 1'b1);
      cyc(busy_st, 1'b1, pa[i], pb[i], 1'b1, 1'b1, 1'b0, {m, opc}, 1'b1, 1'b1);
    end
    cyc(1'b0, pre_v, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, {m, 2'b11}, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, {m, 2'b00}, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, {m, 2'b00}, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    pending_done = 1'b1;
    chk("dot_result", dot_result, er);
    chk("dot_protect", 32'(dot_protect), 32'(ep));
    chk("done_latency", 32'(done_cyc - s_mark), 32'(elat));
  endtask

  task automatic check_reset_outputs();
    chk("rst_instr", 32'(mac_instr), 32'h0);
    chk("rst_stall", 32'(mac_stall), 32'h1);
    chk("rst_mplier", 32'(mac_mplier), 32'h0);
    chk("rst_mcand", 32'(mac_mcand), 32'h0);
    chk("rst_op_ready", 32'(op_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_dot_result", dot_result, 32'h0);
    chk("rst_dot_protect", 32'(dot_protect), 32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    len      = 8'h0;
    op_valid = 1'b1;
    op_a     = 16'h1234;
    op_b     = 16'h5678;
    cur_m    = 1'b0;
    cur_n    = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    idle(2);

    // Mode 0, len 3: (3,4),(2,5),(100,100) -> 10022; start held valid from CLR
    set_pairs(3, 16'h0, 16'h0);
    pa[0] = 16'd3;   pb[0] = 16'd4;
    pa[1] = 16'd2;   pb[1] = 16'd5;
    pa[2] = 16'd100; pb[2] = 16'd100;
    run_job(1'b0, 1'b1, 1'b0, 32'h00002726, 8'h00, 9);

    // Positive saturation, started in the done cycle of the previous job
    set_pairs(3, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 3; i++) pa[i] = 16'h7FFF;
    run_job(1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 8'h00, 9);
    idle(2);

    // Dual-lane 8x8
    set_pairs(2, 16'h0203, 16'h0405);
    for (int i = 0; i < 2; i++) pa[i] = 16'h0203;
    run_job(1'b1, 1'b0, 1'b0, 32'h0010001E, 8'h00, 8);
    idle(1);

    // Three bubble cycles between pairs 1 and 2
    set_pairs(3, 16'h0, 16'h0);
    pa[0] = 16'd3;   pb[0] = 16'd4;
    pa[1] = 16'd2;   pb[1] = 16'd5;
    pa[2] = 16'd100; pb[2] = 16'd100;
    bub[1] = 3;
    run_job(1'b0, 1'b0, 1'b0, 32'h00002726, 8'h00, 12);
    idle(1);

    // len 0 with op_valid offered: op_ready must stay low
    set_pairs(0, 16'hABCD, 16'h4321);
    run_job(1'b0, 1'b1, 1'b0, 32'h00000000, 8'h00, 6);
    idle(1);

    // Negative saturation
    set_pairs(3, 16'h8000, 16'h7FFF);
    for (int i = 0; i < 3; i++) pa[i] = 16'h8000;
    run_job(1'b0, 1'b0, 1'b0, 32'h80000000, 8'hFF, 9);
    idle(1);

    // Reset in the middle of OPS of the saturating job
    set_pairs(3, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 3; i++) pa[i] = 16'h7FFF;
    cur_m = 1'b0;
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, pa[0], pb[0], 1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    op_valid = 1'b1;
    op_a     = 16'h7FFF;
    op_b     = 16'h7FFF;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Rerun case 1 with start pulses while busy
    set_pairs(3, 16'h0, 16'h0);
    pa[0] = 16'd3;   pb[0] = 16'd4;
    pa[1] = 16'd2;   pb[1] = 16'd5;
    pa[2] = 16'd100; pb[2] = 16'd100;
    bub[1] = 1;
    run_job(1'b0, 1'b0, 1'b1, 32'h00002726, 8'h00, 10);
    idle(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
